// File: rtl/filter.sv
// Cascaded integrator-comb moving-average filter, 1:1 rate, unity DC gain.
// N integrators, then N comb stages of differential delay M; output is the top DATA_W bits.

module filter_comb #(
  parameter int W   = 38,
  parameter int DLY = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);
  logic [DLY-1:0][W-1:0] dl;

  // dl[DLY-1] holds d_in from DLY cycles ago
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dl    <= '0;
      d_out <= '0;
    end else begin
      dl    <= {dl[DLY-2:0], d_in};
      d_out <= d_in - dl[DLY-1];
    end
  end
endmodule

module filter #(
  parameter int DATA_W   = 32,
  parameter int N_STAGES = 3,
  parameter int DIFF_DLY = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] x_in,
  output logic [DATA_W-1:0] y_out
);
  localparam int LOG2_M = $clog2(DIFF_DLY);
  localparam int SHIFT  = N_STAGES * LOG2_M;
  localparam int ACC_W  = DATA_W + SHIFT;

  logic [ACC_W-1:0]                 xr;
  logic [N_STAGES-1:0][ACC_W-1:0]   integ;
  logic [N_STAGES-1:0][ACC_W-1:0]   integ_src;
  logic [ACC_W-1:0]                 comb_in  [N_STAGES];
  logic [ACC_W-1:0]                 comb_out [N_STAGES];
  logic [SHIFT-1:0]                 frac_unused;

  always_comb begin
    integ_src    = '0;
    integ_src[0] = xr;
    for (int k = 1; k < N_STAGES; k++) integ_src[k] = integ[k-1];
  end

  // Integrators wrap modulo 2^ACC_W; the combs cancel the wrap exactly
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xr    <= '0;
      integ <= '0;
    end else begin
      xr <= {{(ACC_W-DATA_W){x_in[DATA_W-1]}}, x_in};
      for (int k = 0; k < N_STAGES; k++) integ[k] <= integ[k] + integ_src[k];
    end
  end

  always_comb begin
    for (int k = 0; k < N_STAGES; k++) comb_in[k] = '0;
    comb_in[0] = integ[N_STAGES-1];
    for (int k = 1; k < N_STAGES; k++) comb_in[k] = comb_out[k-1];
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    filter_comb #(.W(ACC_W), .DLY(DIFF_DLY)) u_comb (
      .clock (clock),
      .reset (reset),
      .d_in  (comb_in[g]),
      .d_out (comb_out[g])
    );
  end

  // Dropping the low SHIFT bits is an arithmetic >>> log2(M^N) with floor rounding
  assign y_out       = comb_out[N_STAGES-1][ACC_W-1 -: DATA_W];
  assign frac_unused = comb_out[N_STAGES-1][SHIFT-1:0];
endmodule

// File: tb/tb_filter.sv
// Directed bench for the CIC moving-average filter (N=3, M=4, latency 7).
// Hand tables for impulse/step; direct-form FIR model for extremes and random data.

module tb_filter;
  logic        clock;
  logic        reset;
  logic [31:0] x_in;
  logic [31:0] y_out;

  int checks = 0;
  int errors = 0;

  int     hcoef [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
  longint xh    [16];

  filter dut (
    .clock (clock),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_y();
    longint s = 0;
    for (int j = 0; j < 10; j++) s += longint'(hcoef[j]) * xh[6+j];
    return 32'(s >>> 6);
  endfunction

  task automatic clear_hist();
    for (int j = 0; j < 16; j++) xh[j] = 0;
  endtask

  // Advance one edge, record the sample it consumed, leave time 1 unit after the edge
  task automatic tick();
    @(posedge clock);
    if (!reset) clear_hist();
    else begin
      for (int j = 15; j > 0; j--) xh[j] = xh[j-1];
      xh[0] = longint'($signed(x_in));
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_in = $urandom;
      tick();
      checks++;
      if (y_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got %h want 0", i, y_out);
      end
    end
    reset = 1'b1;
    x_in  = 32'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (y_out !== 32'd0) begin
        errors++;
        $display("FAIL reset_release cyc %0d: got %h want 0", i, y_out);
      end
    end
  endtask

  task automatic test_impulse();
    int imp [16] = '{0, 0, 0, 0, 0, 0, 1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    int e;
    for (int i = 0; i < 24; i++) begin
      x_in = (i == 0) ? 32'd64 : 32'd0;
      tick();
      e = (i < 16) ? imp[i] : 0;
      checks++;
      if ($signed(y_out) !== e) begin
        errors++;
        $display("FAIL impulse cyc %0d: got %0d want %0d", i, $signed(y_out), e);
      end
    end
  endtask

  task automatic test_step();
    int pos [10] = '{15, 62, 156, 312, 500, 687, 843, 937, 984, 1000};
    int neg [10] = '{-16, -63, -157, -313, -500, -688, -844, -938, -985, -1000};
    int e;
    for (int i = 0; i < 24; i++) begin
      x_in = 32'd1000;
      tick();
      e = (i < 6) ? 0 : (i < 16) ? pos[i-6] : 1000;
      checks++;
      if ($signed(y_out) !== e) begin
        errors++;
        $display("FAIL step_pos cyc %0d: got %0d want %0d", i, $signed(y_out), e);
      end
    end
    // Flush back to zero; the filter is linear so the negative step starts clean
    x_in = 32'd0;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (y_out !== 32'd0) begin
      errors++;
      $display("FAIL step_flush: got %0d want 0", $signed(y_out));
    end
    for (int i = 0; i < 24; i++) begin
      x_in = -32'sd1000;
      tick();
      e = (i < 6) ? 0 : (i < 16) ? neg[i-6] : -1000;
      checks++;
      if ($signed(y_out) !== e) begin
        errors++;
        $display("FAIL step_neg cyc %0d: got %0d want %0d", i, $signed(y_out), e);
      end
    end
  endtask

  task automatic test_extremes();
    logic [31:0] e;
    for (int i = 0; i < 220; i++) begin
      x_in = (i >= 200 || i[0] == 1'b0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      tick();
      e = model_y();
      checks++;
      if (y_out !== e) begin
        errors++;
        $display("FAIL extremes cyc %0d: got %h want %h", i, y_out, e);
      end
      if (i >= 215) begin
        checks++;
        if (y_out !== 32'h7FFF_FFFF) begin
          errors++;
          $display("FAIL extremes_settle cyc %0d: got %h want 7fffffff", i, y_out);
        end
      end
    end
  endtask

  task automatic test_midstream_reset();
    int ramp [10] = '{7, 31, 78, 156, 250, 343, 421, 468, 492, 500};
    int e;
    x_in = 32'd0;
    for (int i = 0; i < 16; i++) tick();
    for (int i = 0; i < 20; i++) begin
      x_in = 32'd500;
      tick();
    end
    checks++;
    if ($signed(y_out) !== 500) begin
      errors++;
      $display("FAIL midrst_pre: got %0d want 500", $signed(y_out));
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (y_out !== 32'd0) begin
      errors++;
      $display("FAIL midrst_async: got %0d want 0", $signed(y_out));
    end
    #1 reset = 1'b1;
    clear_hist();
    for (int i = 0; i < 20; i++) begin
      tick();
      e = (i < 6) ? 0 : (i < 16) ? ramp[i-6] : 500;
      checks++;
      if ($signed(y_out) !== e) begin
        errors++;
        $display("FAIL midrst_ramp cyc %0d: got %0d want %0d", i, $signed(y_out), e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    for (int i = 0; i < 1000; i++) begin
      x_in = $urandom;
      tick();
      e = model_y();
      checks++;
      if (y_out !== e) begin
        errors++;
        $display("FAIL random cyc %0d: got %h want %h", i, y_out, e);
      end
    end
  endtask

  initial begin
    clear_hist();
    reset = 1'b1;
    x_in  = 32'd0;
    #1 reset = 1'b0;
    test_reset();
    test_impulse();
    test_step();
    test_extremes();
    test_midstream_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
